// File: rtl/aux_request_encoder.sv
// AUX channel transmit encoder: takes one request plus write payload and emits it as a
// contiguous byte frame (header, optional LEN, payload), followed by a one-cycle done gap.
module aux_request_encoder #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic              req_addr_only,
    input  logic              req_vld,
    output logic              req_ready,
    input  logic [7:0]        wr_data,
    input  logic              wr_data_vld,
    output logic              wr_data_ready,
    output logic [7:0]        aux_out,
    output logic              aux_out_vld,
    output logic              aux_done,
    output logic              tx_err,
    output logic              tx_i2c_native
);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_DATA, HDR, DATA, GAP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic              addr_only_q, addr_only_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        aux_out_q, aux_out_d;
    logic              aux_out_vld_q, aux_out_vld_d;
    logic              aux_done_q, aux_done_d;
    logic              tx_err_q, tx_err_d;
    logic              native_q, native_d;

    logic [7:0]        fifo_q [MAX_LEN];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop, flush;

    logic [19:0]       addr_ext;
    logic [8:0]        need;
    logic              enough, oversize, req_is_wr;
    logic [7:0]        hdr_last, hdr_byte;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign addr_ext  = 20'(addr_q);
    assign need      = {1'b0, len_q} + 9'd1;
    assign enough    = 9'(count_q) >= need;
    assign oversize  = {1'b0, len_q} >= 9'(MAX_LEN);
    assign req_is_wr = (req_cmd[1:0] == 2'b00) && !req_addr_only;
    assign hdr_last  = addr_only_q ? 8'd2 : 8'd3;
    assign push      = wr_data_vld && wr_data_ready;

    // Next-state and request latching; the error pulse is decided at accept so it lands in CHECK.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        addr_only_d = addr_only_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        native_d    = native_q;
        tx_err_d    = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    cmd_d       = req_cmd;
                    addr_d      = req_addr;
                    len_d       = req_len;
                    addr_only_d = req_addr_only;
                    is_wr_d     = req_is_wr;
                    native_d    = ~req_cmd[3];
                    tx_err_d    = req_is_wr && ({1'b0, req_len} >= 9'(MAX_LEN));
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (is_wr_q && oversize) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (is_wr_q && !enough) begin
                    state_d = WAIT_DATA;
                end else begin
                    state_d = HDR;
                    cnt_d   = 8'd0;
                end
            end
            WAIT_DATA: begin
                if (enough) begin
                    state_d = HDR;
                    cnt_d   = 8'd0;
                end
            end
            HDR: begin
                if (cnt_q == hdr_last) begin
                    cnt_d   = 8'd0;
                    state_d = is_wr_q ? DATA : GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == len_q) state_d = GAP;
                else                cnt_d   = cnt_q + 8'd1;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded with what the next state shows, so the bus is glitch-free.
    always_comb begin
        hdr_byte = len_q;
        case (cnt_d[1:0])
            2'd0:    hdr_byte = {cmd_q, addr_ext[19:16]};
            2'd1:    hdr_byte = addr_ext[15:8];
            2'd2:    hdr_byte = addr_ext[7:0];
            default: hdr_byte = len_q;
        endcase
        pop           = (state_d == DATA);
        aux_out_vld_d = (state_d == HDR) || (state_d == DATA);
        aux_done_d    = (state_d == GAP);
        aux_out_d     = 8'h00;
        if (state_d == HDR)       aux_out_d = hdr_byte;
        else if (state_d == DATA) aux_out_d = fifo_q[rd_ptr_q];
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            addr_only_q   <= 1'b0;
            is_wr_q       <= 1'b0;
            cnt_q         <= '0;
            aux_out_q     <= '0;
            aux_out_vld_q <= 1'b0;
            aux_done_q    <= 1'b0;
            tx_err_q      <= 1'b0;
            native_q      <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            addr_only_q   <= addr_only_d;
            is_wr_q       <= is_wr_d;
            cnt_q         <= cnt_d;
            aux_out_q     <= aux_out_d;
            aux_out_vld_q <= aux_out_vld_d;
            aux_done_q    <= aux_done_d;
            tx_err_q      <= tx_err_d;
            native_q      <= native_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) fifo_q[wr_ptr_q] <= wr_data;
    end

    assign req_ready     = (state_q == IDLE);
    assign wr_data_ready = (count_q < CNT_W'(MAX_LEN));
    assign aux_out       = aux_out_q;
    assign aux_out_vld   = aux_out_vld_q;
    assign aux_done      = aux_done_q;
    assign tx_err        = tx_err_q;
    assign tx_i2c_native = native_q;
endmodule

// File: tb/tb_aux_request_encoder.sv
// Bench for aux_request_encoder: table of known frames, reset abort sequence, and random
// requests checked against a transaction-level frame model.
module tb_aux_request_encoder;
    localparam int MAX_LEN = 16;
    localparam int ADDR_W  = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req_cmd = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_len = '0;
    logic              req_addr_only = 1'b0;
    logic              req_vld = 1'b0;
    logic              req_ready;
    logic [7:0]        wr_data = '0;
    logic              wr_data_vld = 1'b0;
    logic              wr_data_ready;
    logic [7:0]        aux_out;
    logic              aux_out_vld;
    logic              aux_done;
    logic              tx_err;
    logic              tx_i2c_native;

    aux_request_encoder #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
        .req_addr_only(req_addr_only), .req_vld(req_vld), .req_ready(req_ready),
        .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_data_ready(wr_data_ready),
        .aux_out(aux_out), .aux_out_vld(aux_out_vld), .aux_done(aux_done),
        .tx_err(tx_err), .tx_i2c_native(tx_i2c_native)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       cmd;
        logic [19:0]      addr;
        logic [7:0]       len;
        logic             ao;
        logic [4:0]       pre_n;
        logic [4:0]       late_n;
        logic [15:0][7:0] dat;
        logic             err;
        logic             native;
        logic [7:0]       first;
        logic [4:0]       exp_n;
        logic [19:0][7:0] exp_b;
    } vec_t;

    vec_t       tbl[$];
    int         vec_cnt = 0;
    int         miss_cnt = 0;
    logic [7:0] mq[$];
    logic [7:0] late_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         first_cyc, done_cyc, err_cnt, gaps, zero_viol, native_seen, ready_at2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Model FIFO only holds what the DUT would have accepted.
    task automatic push_byte(input logic [7:0] b);
        wr_data     = b;
        wr_data_vld = 1'b1;
        checkOutput("wr_data_ready", int'(wr_data_ready), int'(mq.size() < MAX_LEN));
        if (mq.size() < MAX_LEN) mq.push_back(b);
        tick();
        wr_data_vld = 1'b0;
    endtask

    task automatic model_expect(input logic [3:0] cmd, input logic [19:0] addr,
                                input logic [7:0] len, input logic ao, output int exp_err);
        logic is_wr;
        is_wr = (cmd[1:0] == 2'b00) && !ao;
        exp_q.delete();
        exp_err = 0;
        if (is_wr && int'(len) >= MAX_LEN) begin
            exp_err = 1;
            mq.delete();
            return;
        end
        exp_q.push_back({cmd, addr[19:16]});
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        if (!ao) exp_q.push_back(len);
        if (is_wr) for (int i = 0; i <= int'(len); i++) exp_q.push_back(mq.pop_front());
    endtask

    task automatic run_req(input logic [3:0] cmd, input logic [19:0] addr,
                           input logic [7:0] len, input logic ao);
        logic prev_vld;
        prev_vld  = 1'b0;
        got.delete();
        first_cyc = -1; done_cyc = -1; err_cnt = 0; gaps = 0; zero_viol = 0; ready_at2 = -1;
        req_cmd = cmd; req_addr = addr; req_len = len; req_addr_only = ao; req_vld = 1'b1;
        checkOutput("req_ready_idle", int'(req_ready), 1);
        tick();
        native_seen = int'(tx_i2c_native);
        for (int c = 1; c <= 100; c++) begin
            if (tx_err) err_cnt++;
            if (c == 1) checkOutput("req_ready_busy", int'(req_ready), 0);
            if (c == 2) ready_at2 = int'(req_ready);
            if (aux_out_vld) begin
                if (first_cyc < 0) first_cyc = c;
                else if (!prev_vld) gaps++;
                got.push_back(aux_out);
            end else if (aux_out != 8'h00) begin
                zero_viol++;
            end
            if (aux_done && done_cyc < 0) done_cyc = c;
            prev_vld = aux_out_vld;
            if (done_cyc >= 0 || (err_cnt > 0 && c >= 3)) break;
            // Junk requests while busy must be ignored
            req_vld       = (c == 1) || (first_cyc >= 0);
            req_cmd       = 4'($urandom);
            req_addr      = 20'($urandom);
            req_len       = 8'($urandom);
            req_addr_only = 1'($urandom);
            if (c >= 5 && late_q.size() > 0) begin
                wr_data     = late_q.pop_front();
                wr_data_vld = 1'b1;
            end else begin
                wr_data_vld = 1'b0;
            end
            tick();
        end
        req_vld     = 1'b0;
        wr_data_vld = 1'b0;
        checkOutput("request_finished", int'(done_cyc >= 0 || err_cnt > 0), 1);
        tick();
    endtask

    task automatic check_frame(input string tag, input int exp_err, input int exp_native,
                               input int exp_first);
        checkOutput({tag, "_native"}, native_seen, exp_native);
        checkOutput({tag, "_err_pulses"}, err_cnt, exp_err);
        checkOutput({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(exp_q[i]));
        checkOutput({tag, "_zero_when_idle"}, zero_viol, 0);
        if (exp_err != 0) begin
            checkOutput({tag, "_ready_after_err"}, ready_at2, 1);
        end else begin
            checkOutput({tag, "_first_cycle"}, first_cyc, exp_first);
            checkOutput({tag, "_done_cycle"}, done_cyc, first_cyc + exp_q.size());
            checkOutput({tag, "_gaps"}, gaps, 0);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int exp_err;
        for (int k = 0; k < int'(v.pre_n); k++) push_byte(v.dat[k]);
        if (int'(v.pre_n) == MAX_LEN) push_byte(8'hEE);
        late_q.delete();
        for (int k = 0; k < int'(v.late_n); k++) begin
            late_q.push_back(v.dat[int'(v.pre_n) + k]);
            mq.push_back(v.dat[int'(v.pre_n) + k]);
        end
        model_expect(v.cmd, v.addr, v.len, v.ao, exp_err);
        exp_q.delete();
        for (int k = 0; k < int'(v.exp_n); k++) exp_q.push_back(v.exp_b[k]);
        run_req(v.cmd, v.addr, v.len, v.ao);
        check_frame($sformatf("row%0d", idx), int'(v.err), int'(v.native), int'(v.first));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [3:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len;
        logic        ao, is_wr;
        int          exp_err, late_n, nv;
        logic        reached;

        v = '0; v.cmd = 4'h9; v.addr = 20'h00123; v.len = 8'h0F; v.first = 8'd2; v.exp_n = 5'd4;
        v.exp_b[0] = 8'h90; v.exp_b[1] = 8'h01; v.exp_b[2] = 8'h23; v.exp_b[3] = 8'h0F;
        tbl.push_back(v);
        v = '0; v.cmd = 4'h8; v.addr = 20'h00202; v.len = 8'h01; v.pre_n = 5'd2;
        v.dat[0] = 8'hAA; v.dat[1] = 8'h55; v.first = 8'd2; v.exp_n = 5'd6;
        v.exp_b[0] = 8'h80; v.exp_b[1] = 8'h02; v.exp_b[2] = 8'h02; v.exp_b[3] = 8'h01;
        v.exp_b[4] = 8'hAA; v.exp_b[5] = 8'h55;
        tbl.push_back(v);
        v.pre_n = 5'd0; v.late_n = 5'd2; v.first = 8'd8;
        tbl.push_back(v);
        v = '0; v.cmd = 4'h4; v.addr = 20'h00050; v.ao = 1'b1; v.native = 1'b1; v.first = 8'd2;
        v.exp_n = 5'd3; v.exp_b[0] = 8'h40; v.exp_b[1] = 8'h00; v.exp_b[2] = 8'h50;
        tbl.push_back(v);
        v = '0; v.cmd = 4'h8; v.addr = 20'h00202; v.len = 8'h10; v.pre_n = 5'd16; v.err = 1'b1;
        for (int i = 0; i < 16; i++) v.dat[i] = 8'(i);
        tbl.push_back(v);
        v = '0; v.cmd = 4'h8; v.addr = 20'h00000; v.len = 8'h0F; v.pre_n = 5'd16;
        v.first = 8'd2; v.exp_n = 5'd20;
        v.exp_b[0] = 8'h80; v.exp_b[1] = 8'h00; v.exp_b[2] = 8'h00; v.exp_b[3] = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            v.dat[i]       = 8'h30 + 8'(i);
            v.exp_b[4 + i] = 8'h30 + 8'(i);
        end
        tbl.push_back(v);
        v = '0; v.cmd = 4'h4; v.addr = 20'hF1234; v.len = 8'h02; v.pre_n = 5'd3; v.native = 1'b1;
        v.dat[0] = 8'h11; v.dat[1] = 8'h22; v.dat[2] = 8'h33; v.first = 8'd2; v.exp_n = 5'd7;
        v.exp_b[0] = 8'h4F; v.exp_b[1] = 8'h12; v.exp_b[2] = 8'h34; v.exp_b[3] = 8'h02;
        v.exp_b[4] = 8'h11; v.exp_b[5] = 8'h22; v.exp_b[6] = 8'h33;
        tbl.push_back(v);
        v = '0; v.cmd = 4'h1; v.addr = 20'h00050; v.native = 1'b1; v.first = 8'd2; v.exp_n = 5'd4;
        v.exp_b[0] = 8'h10; v.exp_b[1] = 8'h00; v.exp_b[2] = 8'h50; v.exp_b[3] = 8'h00;
        tbl.push_back(v);
        v = '0; v.cmd = 4'h0; v.addr = 20'h00050; v.ao = 1'b1; v.native = 1'b1; v.first = 8'd2;
        v.exp_n = 5'd3; v.exp_b[0] = 8'h00; v.exp_b[1] = 8'h00; v.exp_b[2] = 8'h50;
        tbl.push_back(v);

        #2 rst = 1'b0;
        #20;
        checkOutput("rst_aux_out", int'(aux_out), 0);
        checkOutput("rst_aux_out_vld", int'(aux_out_vld), 0);
        checkOutput("rst_aux_done", int'(aux_done), 0);
        checkOutput("rst_tx_err", int'(tx_err), 0);
        checkOutput("rst_tx_i2c_native", int'(tx_i2c_native), 0);
        checkOutput("rst_req_ready", int'(req_ready), 1);
        checkOutput("rst_wr_data_ready", int'(wr_data_ready), 1);
        rst = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) applyStimulus(i, tbl[i]);

        // Reset while the second payload byte is on the bus
        for (int k = 0; k < 4; k++) push_byte(8'hC1 + 8'(k));
        req_cmd = 4'h8; req_addr = 20'h00300; req_len = 8'h03; req_addr_only = 1'b0; req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        nv = 0;
        reached = 1'b0;
        for (int c = 0; c < 30 && !reached; c++) begin
            if (aux_out_vld) nv++;
            if (nv == 6) begin
                reached = 1'b1;
                checkOutput("rst_mid_second_payload", int'(aux_out), 8'hC2);
                rst = 1'b0;
                #1;
                checkOutput("rst_mid_vld_drop", int'(aux_out_vld), 0);
                checkOutput("rst_mid_out_zero", int'(aux_out), 0);
            end else begin
                tick();
            end
        end
        checkOutput("rst_mid_reached", int'(reached), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mq.delete();
        tick();
        checkOutput("rst_mid_req_ready", int'(req_ready), 1);
        checkOutput("rst_mid_wr_ready", int'(wr_data_ready), 1);
        checkOutput("rst_mid_aux_done", int'(aux_done), 0);
        push_byte(8'h5A);
        late_q.delete();
        model_expect(4'h8, 20'h00301, 8'h00, 1'b0, exp_err);
        run_req(4'h8, 20'h00301, 8'h00, 1'b0);
        check_frame("post_rst", exp_err, 0, 2);

        for (int t = 0; t < 150; t++) begin
            for (int k = 0, n = $urandom_range(0, 6); k < n; k++) push_byte(8'($urandom));
            cmd   = 4'($urandom);
            addr  = 20'($urandom);
            ao    = ($urandom_range(0, 3) == 0);
            is_wr = (cmd[1:0] == 2'b00) && !ao;
            if (is_wr) len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255))
                                                          : 8'($urandom_range(0, 15));
            else       len = 8'($urandom);
            late_q.delete();
            if (is_wr && int'(len) < MAX_LEN)
                while (mq.size() + late_q.size() < int'(len) + 1) late_q.push_back(8'($urandom));
            late_n = late_q.size();
            foreach (late_q[k]) mq.push_back(late_q[k]);
            model_expect(cmd, addr, len, ao, exp_err);
            run_req(cmd, addr, len, ao);
            check_frame($sformatf("rnd%0d", t), exp_err, int'(!cmd[3]),
                        (late_n > 0) ? 6 + late_n : 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
